// File: rtl/proc_ctrl_fsm.sv
// Control FSM for the simple 9-bit processor: steps T0..T3 and decodes IR into datapath enables.
// Optional build macro ILLEGAL_OP_TRAP_EN adds a sticky ILLEGAL flag for opcode 1xx.
module proc_ctrl_fsm #(
    parameter int NREG = 8,
    parameter int IW   = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic [IW-1:0]   ir,
    output logic            ir_in,
    output logic [NREG-1:0] r_in,
    output logic [NREG-1:0] r_out,
    output logic            din_out,
    output logic            g_out,
    output logic            a_in,
    output logic            g_in,
    output logic            addsub,
    output logic            done,
    output logic [1:0]      state
`ifdef ILLEGAL_OP_TRAP_EN
    ,
    output logic            illegal
`endif
);

    localparam logic [1:0] T0 = 2'd0;
    localparam logic [1:0] T1 = 2'd1;
    localparam logic [1:0] T2 = 2'd2;
    localparam logic [1:0] T3 = 2'd3;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    logic [1:0]      state_reg;
    logic [1:0]      state_next;
    logic [2:0]      opcode;
    logic [2:0]      x_sel;
    logic [2:0]      y_sel;
    logic [NREG-1:0] x_onehot;
    logic [NREG-1:0] y_onehot;

    logic            ir_in_next;
    logic [NREG-1:0] r_in_next;
    logic [NREG-1:0] r_out_next;
    logic            din_out_next;
    logic            g_out_next;
    logic            a_in_next;
    logic            g_in_next;
    logic            addsub_next;
    logic            done_next;
    logic            illegal_set;

    assign opcode = ir[IW-1:IW-3];
    assign x_sel  = ir[5:3];
    assign y_sel  = ir[2:0];

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_onehot
            assign x_onehot[gi] = (x_sel == 3'(gi));
            assign y_onehot[gi] = (y_sel == 3'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= T0;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        ir_in_next   = 1'b0;
        r_in_next    = '0;
        r_out_next   = '0;
        din_out_next = 1'b0;
        g_out_next   = 1'b0;
        a_in_next    = 1'b0;
        g_in_next    = 1'b0;
        addsub_next  = 1'b0;
        done_next    = 1'b0;
        illegal_set  = 1'b0;
        case (state_reg)
            T0: begin
                ir_in_next = run;
                state_next = run ? T1 : T0;
            end
            T1: begin
                case (opcode)
                    OP_MV: begin
                        r_out_next = y_onehot;
                        r_in_next  = x_onehot;
                        done_next  = 1'b1;
                        state_next = T0;
                    end
                    OP_MVI: begin
                        din_out_next = 1'b1;
                        r_in_next    = x_onehot;
                        done_next    = 1'b1;
                        state_next   = T0;
                    end
                    OP_ADD, OP_SUB: begin
                        r_out_next = x_onehot;
                        a_in_next  = 1'b1;
                        state_next = T2;
                    end
                    default: begin
                        // 1xx: finish immediately without touching the datapath
                        done_next   = 1'b1;
                        illegal_set = 1'b1;
                        state_next  = T0;
                    end
                endcase
            end
            T2: begin
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    r_out_next  = y_onehot;
                    g_in_next   = 1'b1;
                    addsub_next = opcode[0];
                    state_next  = T3;
                end else begin
                    state_next = T0;
                end
            end
            T3: begin
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    g_out_next = 1'b1;
                    r_in_next  = x_onehot;
                    done_next  = 1'b1;
                end
                state_next = T0;
            end
            default: begin
                state_next = T0;
            end
        endcase
    end

    // Outputs are forced low for the whole reset pulse, not just from the next edge.
    assign ir_in   = ~rst & ir_in_next;
    assign r_in    = rst ? '0 : r_in_next;
    assign r_out   = rst ? '0 : r_out_next;
    assign din_out = ~rst & din_out_next;
    assign g_out   = ~rst & g_out_next;
    assign a_in    = ~rst & a_in_next;
    assign g_in    = ~rst & g_in_next;
    assign addsub  = ~rst & addsub_next;
    assign done    = ~rst & done_next;
    assign state   = state_reg;

`ifdef ILLEGAL_OP_TRAP_EN
    logic illegal_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_reg <= 1'b0;
        end else if (illegal_set) begin
            illegal_reg <= 1'b1;
        end
    end

    assign illegal = illegal_reg;
`else
    logic unused_illegal;
    assign unused_illegal = illegal_set;
`endif

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Directed bench for proc_ctrl_fsm: each step drives inputs, advances a clock and asserts outputs.
module tb_proc_ctrl_fsm;

    logic       clk;
    logic       rst;
    logic       run;
    logic [8:0] ir;
    logic       ir_in;
    logic [7:0] r_in;
    logic [7:0] r_out;
    logic       din_out;
    logic       g_out;
    logic       a_in;
    logic       g_in;
    logic       addsub;
    logic       done;
    logic [1:0] state;
`ifdef ILLEGAL_OP_TRAP_EN
    logic       illegal;
`endif

    int checks = 0;
    int errors = 0;

    proc_ctrl_fsm #(.NREG(8), .IW(9)) dut (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .ir      (ir),
        .ir_in   (ir_in),
        .r_in    (r_in),
        .r_out   (r_out),
        .din_out (din_out),
        .g_out   (g_out),
        .a_in    (a_in),
        .g_in    (g_in),
        .addsub  (addsub),
        .done    (done),
        .state   (state)
`ifdef ILLEGAL_OP_TRAP_EN
        ,
        .illegal (illegal)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: {ir_in, r_in, r_out, din_out, g_out, a_in, g_in, addsub, done}
    function automatic logic [22:0] ex(input logic iri, input logic [7:0] ri, input logic [7:0] ro,
                                       input logic dino, input logic go, input logic ai,
                                       input logic gin, input logic asb, input logic dn);
        return {iri, ri, ro, dino, go, ai, gin, asb, dn};
    endfunction

    function automatic logic [22:0] obs_outs();
        return {ir_in, r_in, r_out, din_out, g_out, a_in, g_in, addsub, done};
    endfunction

    task automatic chk(input string tag, input logic [22:0] observed, input logic [22:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
        $display("check %s observed=%h expected=%h", tag, observed, expected);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_step(input string tag, input logic [1:0] st, input logic [22:0] outs);
        chk({tag, ".state"}, 23'(state), 23'(st));
        chk({tag, ".outs"}, obs_outs(), outs);
    endtask

    initial begin
        rst = 1'b1;
        run = 1'b0;
        ir  = 9'b0;
        step();
        run = 1'b1;
        #1;
        chk_step("rst_run_high", 2'd0, ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
`ifdef ILLEGAL_OP_TRAP_EN
        chk("rst_illegal", 23'(illegal), 23'd0);
`endif
        run = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk_step("idle_t0", 2'd0, ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));

        // mvi R3,#D
        ir = 9'b001_011_000; run = 1'b1; #1;
        chk_step("mvi_t0", 2'd0, ex(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
        step(); run = 1'b0; #1;
        chk_step("mvi_t1", 2'd1, ex(0, 8'h08, 8'h00, 1, 0, 0, 0, 0, 1));
        step();
        chk_step("mvi_back", 2'd0, ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));

        // mv R5,R2
        ir = 9'b000_101_010; run = 1'b1; #1;
        chk_step("mv_t0", 2'd0, ex(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
        step(); run = 1'b0; #1;
        chk_step("mv_t1", 2'd1, ex(0, 8'h20, 8'h04, 0, 0, 0, 0, 0, 1));
        step();
        chk_step("mv_back", 2'd0, ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));

        // sub R1,R6
        ir = 9'b011_001_110; run = 1'b1; #1;
        chk_step("sub_t0", 2'd0, ex(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
        step(); run = 1'b0; #1;
        chk_step("sub_t1", 2'd1, ex(0, 8'h00, 8'h02, 0, 0, 1, 0, 0, 0));
        step();
        chk_step("sub_t2", 2'd2, ex(0, 8'h00, 8'h40, 0, 0, 0, 1, 1, 0));
        step();
        chk_step("sub_t3", 2'd3, ex(0, 8'h02, 8'h00, 0, 1, 0, 0, 0, 1));
        step();
        chk_step("sub_back", 2'd0, ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));

        // add R1,R6 with RUN held for a single cycle
        ir = 9'b010_001_110; run = 1'b1;
        step(); run = 1'b0; #1;
        chk_step("add_t1", 2'd1, ex(0, 8'h00, 8'h02, 0, 0, 1, 0, 0, 0));
        step();
        chk_step("add_t2", 2'd2, ex(0, 8'h00, 8'h40, 0, 0, 0, 1, 0, 0));
        step();
        chk_step("add_t3", 2'd3, ex(0, 8'h02, 8'h00, 0, 1, 0, 0, 0, 1));
        step();
        chk_step("add_hold0", 2'd0, ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
        step();
        chk_step("add_hold1", 2'd0, ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));

        // mv R2,R2 with RUN held high: back-to-back restart
        ir = 9'b000_010_010; run = 1'b1;
        step();
        chk_step("mvxx_t1", 2'd1, ex(0, 8'h04, 8'h04, 0, 0, 0, 0, 0, 1));
        step();
        chk_step("mvxx_b2b_t0", 2'd0, ex(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));

        // add R3,R3 launched back-to-back; deasserting RUN in T1 does not abort
        ir = 9'b010_011_011;
        step(); run = 1'b0; #1;
        chk_step("addxx_t1", 2'd1, ex(0, 8'h00, 8'h08, 0, 0, 1, 0, 0, 0));
        step();
        chk_step("addxx_t2", 2'd2, ex(0, 8'h00, 8'h08, 0, 0, 0, 1, 0, 0));
        step();
        chk_step("addxx_t3", 2'd3, ex(0, 8'h08, 8'h00, 0, 1, 0, 0, 0, 1));
        step();

        // illegal opcode 110
        ir = 9'b110_000_000; run = 1'b1;
        step(); run = 1'b0; #1;
        chk_step("ill_t1", 2'd1, ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1));
        step();
        chk_step("ill_back", 2'd0, ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
`ifdef ILLEGAL_OP_TRAP_EN
        chk("ill_flag", 23'(illegal), 23'd1);
`endif
        ir = 9'b001_000_000; run = 1'b1;
        step(); run = 1'b0; #1;
        chk_step("post_ill_mvi", 2'd1, ex(0, 8'h01, 8'h00, 1, 0, 0, 0, 0, 1));
        step();
`ifdef ILLEGAL_OP_TRAP_EN
        chk("ill_sticky", 23'(illegal), 23'd1);
`endif

        // asynchronous reset in T2 of an add
        ir = 9'b010_100_101; run = 1'b1;
        step(); run = 1'b0;
        step();
        chk_step("rstmid_t2", 2'd2, ex(0, 8'h00, 8'h20, 0, 0, 0, 1, 0, 0));
        #2 rst = 1'b1;
        #1;
        chk_step("rstmid_async", 2'd0, ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
`ifdef ILLEGAL_OP_TRAP_EN
        chk("rstmid_illegal", 23'(illegal), 23'd0);
`endif
        step();
        rst = 1'b0;
        step();
        chk_step("post_rst_hold", 2'd0, ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
        step();
        chk_step("post_rst_hold2", 2'd0, ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/proc_ctrl_fsm.md
Name: proc_ctrl_fsm

Overview:
- Control unit for the simple 9-bit processor.
- Decodes the 9-bit instruction held in the instruction register (format III XXX YYY).
- Sequences time steps T0..T3 and drives all datapath enables: register load enables, one-hot bus-source selects, A/G latch enables and the add/sub select.
- Its bus-source and enable outputs feed the 9-bit bus multiplexer and register stage directly downstream.

Parameters:
- NREG, 8, number of general registers R0..R(NREG-1); one-hot vector width; fixed at 8 by the 3-bit XXX/YYY fields.
- IW, 9, instruction width; opcode is IR[IW-1:IW-3].

Ports:
- CLK  input  1  single system clock; all state changes on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- RUN  input  1  start request, sampled in T0.
- IR  input  9  current instruction from the external IR register. III=IR[8:6], XXX=IR[5:3], YYY=IR[2:0].
- IR_IN  output  1  IR load enable.
- R_IN  output  8  one-hot register load enables.
- R_OUT  output  8  one-hot register-to-bus drive selects.
- DIN_OUT  output  1  DIN drives bus.
- G_OUT  output  1  G register drives bus.
- A_IN  output  1  A register load enable.
- G_IN  output  1  G register load enable.
- ADDSUB  output  1  ALU op select: 0 = add, 1 = sub.
- DONE  output  1  single-cycle pulse in the last step of each instruction.
- STATE  output  2  current step (T0=0..T3=3); for debug and bench use.

Behaviour:
State register:
- 2-bit state register; all other outputs are combinational decode of state + IR + RUN.
- RST high: state forced to T0 immediately (asynchronous), regardless of clock.
- While RST is high, every output is 0, including IR_IN.
- Reset mid-instruction aborts the instruction; no further enables are issued.

T0:
- IR_IN = RUN.
- Next state is T1 if RUN = 1, else stay in T0.
- All other outputs are 0.

Opcode decode (from IR in T1..T3):
- 000 mv Rx,Ry:
  - T1: R_OUT[y]=1, R_IN[x]=1, DONE=1.
  - Next state T0.
- 001 mvi Rx,#D:
  - T1: DIN_OUT=1, R_IN[x]=1, DONE=1.
  - Next state T0.
- 010 add Rx,Ry:
  - T1: R_OUT[x]=1, A_IN=1.
  - T2: R_OUT[y]=1, G_IN=1, ADDSUB=0.
  - T3: G_OUT=1, R_IN[x]=1, DONE=1.
  - Next states T1->T2->T3->T0.
- 011 sub Rx,Ry:
  - Same sequence as add, with ADDSUB=1 in T2.
  - ADDSUB=0 in every other step.
- 1xx: see Optional Feature.

Rules and boundary conditions:
- Bus-source outputs (R_OUT, DIN_OUT, G_OUT) are at most one-hot across all three in every cycle. All zero means an idle bus.
- R_IN is at most one-hot.
- x == y is legal.
  - mv R2,R2: R_OUT[2] and R_IN[2] asserted together.
  - add R3,R3 computes 2*R3, because A captures R3 in T1.
- RUN is ignored outside T0. Deasserting RUN mid-instruction does not abort the instruction.
- IR must be stable T1..T3. The FSM never asserts IR_IN outside T0.
- Back-to-back instructions: DONE in step Tn is followed by T0 on the next cycle. Minimum 2 cycles for mv/mvi, 4 cycles for add/sub.
- State encodings outside T0..T3 are unreachable. The default branch returns the FSM to T0 with all outputs 0.

Optional Feature:
- Macro: ILLEGAL_OP_TRAP_EN.
- Defined:
  - Adds output ILLEGAL (1 bit, reset 0).
  - In T1, opcode 1xx drives DONE=1 and no other enables, and sets ILLEGAL.
  - ILLEGAL is sticky until RST.
- Not defined:
  - No ILLEGAL port.
  - Opcode 1xx is a NOP: T1 drives DONE=1 only, then returns to T0.
- Sequencing and timing are identical in both builds.

Test Plan:
- Reset: RST=1 asynchronously mid-T2 of an add → STATE=0 and all outputs 0 before the next clock edge. After RST=0 with RUN=0, the FSM holds T0 and IR_IN=0.
- mvi: RUN=1, IR=9'b001_011_000 → T0: IR_IN=1; T1: DIN_OUT=1, R_IN=8'b0000_1000, DONE=1; then back to T0.
- mv: IR=9'b000_101_010 → T1: R_OUT=8'b0000_0100, R_IN=8'b0010_0000, DONE=1. Exactly 2 cycles from T0.
- add/sub: IR=9'b011_001_110 → T1: R_OUT=8'h02, A_IN=1; T2: R_OUT=8'h40, G_IN=1, ADDSUB=1; T3: G_OUT=1, R_IN=8'h02, DONE=1. Repeat with opcode 010 and check ADDSUB=0.
- RUN drop: RUN=1 for one cycle only with an add in IR → all 4 steps complete and DONE pulses once. The FSM then holds T0 with IR_IN=0.
- Illegal opcode: IR=9'b110_000_000 → T1: DONE=1, all enables 0. With ILLEGAL_OP_TRAP_EN, ILLEGAL=1 and stays 1 through later legal instructions until RST.
